rr_mux_arbiter4: RTL and testbench

- Four-requester round-robin arbiter placed directly upstream of the 32-bit 4:1 data mux.
- Generates the mux select from four valid/ready request channels and consumes the mux output into a registered output stage with its own valid/ready handshake.
- Turns the purely combinational selector into a flow-controlled merge point: up to one word per cycle, fair across channels.

---
 rtl/rr_mux_pkg.sv | 42 ++++
 rtl/fourto1mux.sv | 30 +++
 rtl/rr_mux_arbiter4.sv | 113 +++++++++++
 tb/tb_rr_mux_arbiter4.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg
// Shared types, constants and the round-robin search helper for
// rr_mux_arbiter4.
//
// Configuration: RR_MUX_PRIO0_EN is not read here. The top applies channel-0
// priority on top of next_grant() when that macro is defined.
package rr_mux_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] chan_idx_t;

    // Reset value of last_grant. The search starts one past this value, so
    // channel 0 wins the first grant.
    localparam chan_idx_t RESET_LAST_GRANT = 2'b11;

    typedef struct packed {
        logic      found;
        chan_idx_t idx;
    } grant_t;

    // Search order is last+1, last+2, last+3, last+4 (mod 4).
    // The loop walks from the farthest candidate to the nearest one, so the
    // nearest valid channel writes last and wins. When k=4 the 2-bit sum wraps
    // to last itself, which lets a lone requester win again.
    function automatic grant_t next_grant(input chan_idx_t last,
                                          input logic [NUM_CH-1:0] valid);
        grant_t    g;
        chan_idx_t c;
        g.found = 1'b0;
        g.idx   = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            c = last + chan_idx_t'(k);
            if (valid[c]) begin
                g.found = 1'b1;
                g.idx   = c;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/fourto1mux.sv
// fourto1mux
// Purely combinational 4:1 word selector.
//
// Ports:
//   sel        : 2-bit select
//   d0..d3     : N-bit data inputs
//   out        : d[sel]
module fourto1mux #(
    parameter int N = 32
) (
    input  logic [1:0]   sel,
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    input  logic [N-1:0] d2,
    input  logic [N-1:0] d3,
    output logic [N-1:0] out
);

    always_comb begin
        out = d0;
        case (sel)
            2'd0: out = d0;
            2'd1: out = d1;
            2'd2: out = d2;
            2'd3: out = d3;
            default: out = d0;
        endcase
    end

endmodule

// File: rtl/rr_mux_arbiter4.sv
// rr_mux_arbiter4
// A four-channel round-robin arbiter in front of a 4:1 data mux. It has a
// registered output stage with a valid/ready handshake and can merge up to
// one word per cycle.
//
// Ports:
//   clk, rst      : clock; asynchronous active-high reset
//   req_valid[3:0]: per-channel request valid
//   req_ready[3:0]: per-channel take strobe (one-hot or zero)
//   D0..D3        : per-channel N-bit data
//   out_valid     : out_data holds an unconsumed word
//   out_ready     : downstream accepts out_data this cycle
//   out_data      : registered selected word
//   sel           : index of the channel that supplied out_data
//
// Configuration: when `RR_MUX_PRIO0_EN is defined, channel 0 has strict
// priority over the round-robin search.
module rr_mux_arbiter4
    import rr_mux_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req_valid,
    output logic [3:0]   req_ready,
    input  logic [N-1:0] D0,
    input  logic [N-1:0] D1,
    input  logic [N-1:0] D2,
    input  logic [N-1:0] D3,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [1:0]   sel
);

    logic         out_valid_q, out_valid_d;
    logic [N-1:0] out_data_q,  out_data_d;
    chan_idx_t    sel_q,       sel_d;
    chan_idx_t    last_grant_q, last_grant_d;

    logic         free;
    grant_t       gnt;
    logic [N-1:0] mux_out;

    // The mux select is the combinational grant. The selected word is
    // captured on the same edge that accepts the request.
    fourto1mux #(.N(N)) u_mux (
        .sel (gnt.idx),
        .d0  (D0),
        .d1  (D1),
        .d2  (D2),
        .d3  (D3),
        .out (mux_out)
    );

    always_comb begin
        // The output stage can take a new word when it is empty or when its
        // current word retires this cycle.
        free = ~out_valid_q | out_ready;

        gnt = next_grant(last_grant_q, req_valid);
`ifdef RR_MUX_PRIO0_EN
        // Channel 0 overrides the rotation. last_grant still records 0, so
        // the rotation among the other channels picks up from there.
        if (req_valid[0]) begin
            gnt.found = 1'b1;
            gnt.idx   = 2'd0;
        end
`endif

        req_ready = '0;
        if (!rst && free && gnt.found) begin
            req_ready[gnt.idx] = 1'b1;
        end

        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        if (free) begin
            if (gnt.found) begin
                out_valid_d  = 1'b1;
                out_data_d   = mux_out;
                sel_d        = gnt.idx;
                last_grant_d = gnt.idx;
            end else begin
                // The word (if any) retired and nothing replaces it. Data and
                // sel keep their last values.
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            sel_q        <= '0;
            last_grant_q <= RESET_LAST_GRANT;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sel       = sel_q;

endmodule

// File: tb/tb_rr_mux_arbiter4.sv
// tb_rr_mux_arbiter4
// Scoreboard bench for rr_mux_arbiter4.
// The driver changes inputs 2 time units after each rising edge.
// 1 time unit later it checks req_ready and out_valid against a reference
// model, and pushes every accepted word into a queue.
// The monitor samples on each falling edge. It compares the presented word
// with the head of the queue, and pops on each output handshake.
// The model follows `RR_MUX_PRIO0_EN in the same way as the design build.
module tb_rr_mux_arbiter4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [31:0] D0 = '0, D1 = '0, D2 = '0, D3 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [1:0]  sel;

    rr_mux_arbiter4 #(.N(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .D0        (D0),
        .D1        (D1),
        .D2        (D2),
        .D3        (D3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sel       (sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;

    // Reference model state
    int          m_last  = 3;
    bit          m_valid = 1'b0;
    logic [31:0] hold_data = '0;
    int          hold_sel  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of stimulus, checks the handshake outputs and
    // advances the model.
    task automatic tick(input logic [3:0] v, input logic rdy,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3);
        logic [31:0] dd[4];
        bit          free, found;
        int          g;
        logic [3:0]  exp_rr;
        exp_t        e;
        @(posedge clk);
        #2;
        req_valid = v; out_ready = rdy;
        D0 = d0; D1 = d1; D2 = d2; D3 = d3;
        dd[0] = d0; dd[1] = d1; dd[2] = d2; dd[3] = d3;
        #1;
        free  = !m_valid || rdy;
        found = 1'b0;
        g     = 0;
`ifdef RR_MUX_PRIO0_EN
        if (v[0]) begin found = 1'b1; g = 0; end
`endif
        for (int k = 1; k <= 4; k++) begin
            if (!found && v[(m_last + k) % 4]) begin
                found = 1'b1;
                g = (m_last + k) % 4;
            end
        end
        exp_rr = '0;
        if (free && found) exp_rr[g] = 1'b1;
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("req_ready", 64'(req_ready), 64'(exp_rr));
        if (free) begin
            if (found) begin
                e.ch = g; e.data = dd[g];
                sb.push_back(e);
                m_last  = g;
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_last    = 3;
        m_valid   = 1'b0;
        hold_data = '0;
        hold_sel  = 0;
    endtask

    // Monitor: pop and compare whenever the DUT presents a word
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 64'(1), 64'(0));
                    end else begin
                        e = sb[0];
                        chk("out_data", 64'(out_data), 64'(e.data));
                        chk("sel", 64'(sel), 64'(e.ch));
                        if (out_ready) begin
                            void'(sb.pop_front());
                            hold_data = e.data;
                            hold_sel  = e.ch;
                        end
                    end
                end else begin
                    chk("idle_data", 64'(out_data), 64'(hold_data));
                    chk("idle_sel", 64'(sel), 64'(hold_sel));
                end
            end
        end
    end

    initial begin
        logic [3:0]  rv;
        logic [31:0] rd[4];
        logic [3:0]  pend;
        bit          rr;

        // Reset state, with requests present so that req_ready is gated
        req_valid = 4'b1111; out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_sel", 64'(sel), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        @(posedge clk); #2; rst = 1'b0; req_valid = '0;
        model_reset();

        // Full rotation, including the data corner patterns
        repeat (5) tick(4'b1111, 1'b1, 32'h0, 32'h1, 32'hAAAAAAAA, 32'h80000001);
        // Grant to channel 1, then hold it under backpressure
        tick(4'b1111, 1'b1, 32'h0, 32'h1, 32'hAAAAAAAA, 32'h80000001);
        repeat (3) tick(4'b1111, 1'b0, 32'h0, 32'h1, 32'hAAAAAAAA, 32'h80000001);
        tick(4'b1111, 1'b1, 32'h0, 32'h1, 32'hAAAAAAAA, 32'h80000001);
        // Sparse requests: last=1, then 1001 -> channel 3, then channel 0
        tick(4'b0010, 1'b1, 32'h10, 32'h11, 32'h12, 32'h13);
        tick(4'b1001, 1'b1, 32'h20, 32'h21, 32'h22, 32'h23);
        tick(4'b1001, 1'b1, 32'h30, 32'h31, 32'h32, 32'h33);
        // Idle
        repeat (3) tick(4'b0000, 1'b1, 32'h40, 32'h41, 32'h42, 32'h43);
        // Single requester that repeats
        repeat (3) tick(4'b0100, 1'b1, 32'h50, 32'h51, 32'h52, 32'h53);

        // Async reset between edges while a word is pending
        tick(4'b1111, 1'b0, 32'h61, 32'h62, 32'h63, 32'h64);
        tick(4'b0000, 1'b0, 32'h61, 32'h62, 32'h63, 32'h64);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_out_data", 64'(out_data), 64'(0));
        chk("arst_sel", 64'(sel), 64'(0));
        chk("arst_req_ready", 64'(req_ready), 64'(0));
        model_reset();
        @(posedge clk); #2; rst = 1'b0;
        repeat (3) tick(4'b0110, 1'b1, 32'h70, 32'h71, 32'h72, 32'h73);

        // Randomised traffic. A channel's data stays stable while it waits.
        pend = '0;
        rv   = '0;
        for (int i = 0; i < 4; i++) rd[i] = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i]) begin
                    rv[i] = ($urandom_range(0, 99) < 60);
                    rd[i] = $urandom;
                end
            end
            rr = ($urandom_range(0, 99) < 70);
            tick(rv, rr, rd[0], rd[1], rd[2], rd[3]);
            pend = rv & ~req_ready;
        end

        // Drain
        repeat (3) tick(4'b0000, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk); #1;
        chk("sb_drained", 64'(sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
